// File: rtl/i2c_pkg.sv
// Shared types for the I2C register slave: FSM state encoding and bit-counter width.
package i2c_pkg;

  localparam int unsigned BitCntW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StRxData,
    StRxAck,
    StTxData,
    StTxAck,
    StWaitStop
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Line conditioner: 2-flop synchronizer, optional 3-tap majority filter (I2C_GLITCH_FILTER_EN),
// then a registered rise/fall detector. Idle bus level is high, so everything resets to 1.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [1:0] r_sync;
  logic       w_clean;
  logic       r_prev;
  logic       r_rise;
  logic       r_fall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_line};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] r_tap;
  logic       r_filt;

  // A one-cycle pulse never occupies two of the three taps at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tap  <= 2'b11;
      r_filt <= 1'b1;
    end else begin
      r_tap  <= {r_tap[0], r_sync[1]};
      r_filt <= (r_sync[1] & r_tap[0]) | (r_sync[1] & r_tap[1]) | (r_tap[0] & r_tap[1]);
    end
  end

  assign w_clean = r_filt;
`else
  assign w_clean = r_sync[1];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= w_clean;
      r_rise <= w_clean & ~r_prev;
      r_fall <= ~w_clean & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C single-register slave: one 7-bit address, a write register (IOout) and a read register
// (IOin), with stretched completion strobes. Define I2C_GLITCH_FILTER_EN to filter SCL/SDA.
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0]  I2C_ADR     = 7'h27,
  parameter int unsigned ACK_STRETCH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [7:0] IOin,
  output logic [7:0] IOout,
  output logic       serialTxDataAck,
  output logic       serialRxDataAck
);
  localparam logic [BitCntW-1:0] LastBit   = BitCntW'(8);
  localparam logic [BitCntW-1:0] CntOne    = BitCntW'(1);
  localparam logic [3:0]         StretchLd = 4'(ACK_STRETCH);

  logic w_scl_level, w_scl_rise, w_scl_fall;
  logic w_sda_level, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_state_e         r_state, w_state_nxt;
  logic [BitCntW-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]         r_shift, w_shift_nxt;
  logic [7:0]         r_io_out, w_io_out_nxt;
  logic               r_rw, w_rw_nxt;
  logic               r_sda_oe, w_sda_oe_nxt;
  logic [3:0]         r_rx_cnt, w_rx_cnt_nxt;
  logic [3:0]         r_tx_cnt, w_tx_cnt_nxt;

  i2c_line_sync u_scl_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_line  (SCL),
    .o_level (w_scl_level),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_line  (SDA),
    .o_level (w_sda_level),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl_level;
  assign w_stop  = w_sda_rise & w_scl_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_bit_cnt <= '0;
      r_shift   <= 8'h00;
      r_io_out  <= 8'h00;
      r_rw      <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_rx_cnt  <= 4'd0;
      r_tx_cnt  <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_io_out  <= w_io_out_nxt;
      r_rw      <= w_rw_nxt;
      r_sda_oe  <= w_sda_oe_nxt;
      r_rx_cnt  <= w_rx_cnt_nxt;
      r_tx_cnt  <= w_tx_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_io_out_nxt  = r_io_out;
    w_rw_nxt      = r_rw;
    w_sda_oe_nxt  = r_sda_oe;
    w_rx_cnt_nxt  = (r_rx_cnt != 4'd0) ? r_rx_cnt - 4'd1 : 4'd0;
    w_tx_cnt_nxt  = (r_tx_cnt != 4'd0) ? r_tx_cnt - 4'd1 : 4'd0;

    if (w_stop) begin
      w_state_nxt  = StIdle;
      w_sda_oe_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt   = StAddr;
      w_bit_cnt_nxt = '0;
      w_sda_oe_nxt  = 1'b0;
    end else begin
      case (r_state)
        StAddr: begin
          if (w_scl_rise) begin
            w_shift_nxt   = {r_shift[6:0], w_sda_level};
            w_bit_cnt_nxt = r_bit_cnt + CntOne;
          end else if (w_scl_fall && r_bit_cnt == LastBit) begin
            w_bit_cnt_nxt = '0;
            if (r_shift[7:1] == I2C_ADR) begin
              w_state_nxt  = StAddrAck;
              w_sda_oe_nxt = 1'b1;
              w_rw_nxt     = r_shift[0];
            end else begin
              w_state_nxt = StWaitStop;
            end
          end
        end
        StAddrAck: begin
          if (w_scl_fall) begin
            if (r_rw) begin
              w_state_nxt   = StTxData;
              w_shift_nxt   = IOin;
              w_sda_oe_nxt  = ~IOin[7];
              w_bit_cnt_nxt = CntOne;
            end else begin
              w_state_nxt   = StRxData;
              w_sda_oe_nxt  = 1'b0;
              w_bit_cnt_nxt = '0;
            end
          end
        end
        StRxData: begin
          if (w_scl_rise) begin
            w_shift_nxt   = {r_shift[6:0], w_sda_level};
            w_bit_cnt_nxt = r_bit_cnt + CntOne;
          end else if (w_scl_fall && r_bit_cnt == LastBit) begin
            w_state_nxt   = StRxAck;
            w_sda_oe_nxt  = 1'b1;
            w_io_out_nxt  = r_shift;
            w_rx_cnt_nxt  = StretchLd;
            w_bit_cnt_nxt = '0;
          end
        end
        StRxAck: begin
          if (w_scl_fall) begin
            w_state_nxt  = StRxData;
            w_sda_oe_nxt = 1'b0;
          end
        end
        StTxData: begin
          // Bit count 0 means the previous ACK clock just ended: load a fresh byte.
          if (w_scl_fall) begin
            if (r_bit_cnt == '0) begin
              w_shift_nxt   = IOin;
              w_sda_oe_nxt  = ~IOin[7];
              w_bit_cnt_nxt = CntOne;
            end else if (r_bit_cnt == LastBit) begin
              w_state_nxt   = StTxAck;
              w_sda_oe_nxt  = 1'b0;
              w_bit_cnt_nxt = '0;
            end else begin
              w_shift_nxt   = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt  = ~r_shift[6];
              w_bit_cnt_nxt = r_bit_cnt + CntOne;
            end
          end
        end
        StTxAck: begin
          if (w_scl_rise) begin
            w_tx_cnt_nxt = StretchLd;
            w_state_nxt  = w_sda_level ? StWaitStop : StTxData;
          end
        end
        default: ;
      endcase
    end
  end

  assign SDA             = r_sda_oe ? 1'b0 : 1'bz;
  assign IOout           = r_io_out;
  assign serialRxDataAck = (r_rx_cnt != 4'd0);
  assign serialTxDataAck = (r_tx_cnt != 4'd0);

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: a bit-level I2C host plus a transaction-level model of the register
// slave (acks, IOout, strobe counts and widths, read data).
module tb_i2c_reg_slave;
  localparam logic [6:0] Adr     = 7'h27;
  localparam int         Stretch = 4;
  localparam int         Q       = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       host_sda_low = 1'b0;
  logic [7:0] io_in = 8'h00;
  logic [7:0] io_out;
  logic       tx_ack;
  logic       rx_ack;
  wire        sda_line;

  assign sda_line = host_sda_low ? 1'b0 : 1'bz;
  pullup (sda_line);

  always #5 clk = ~clk;

  i2c_reg_slave #(
    .I2C_ADR     (Adr),
    .ACK_STRETCH (Stretch)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .SCL             (scl),
    .SDA             (sda_line),
    .IOin            (io_in),
    .IOout           (io_out),
    .serialTxDataAck (tx_ack),
    .serialRxDataAck (rx_ack)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Bus monitor: strobe pulses/widths, slave pull-downs, IOout changes outside a strobe rise.
  int         rx_pulses = 0, tx_pulses = 0, rx_run = 0, tx_run = 0;
  int         bad_widths = 0, io_bad = 0, dut_low_cnt = 0;
  logic [7:0] io_prev = 8'h00;
  logic       rx_prev = 1'b0;

  always @(negedge clk) begin
    if (!host_sda_low && sda_line === 1'b0) dut_low_cnt++;
    if (reset_n && io_out !== io_prev && !(rx_ack && !rx_prev)) io_bad++;
    io_prev = io_out;
    rx_prev = rx_ack;
    if (rx_ack) rx_run++;
    else if (rx_run != 0) begin
      rx_pulses++;
      if (rx_run != Stretch) bad_widths++;
      rx_run = 0;
    end
    if (tx_ack) tx_run++;
    else if (tx_run != 0) begin
      tx_pulses++;
      if (tx_run != Stretch) bad_widths++;
      tx_run = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    host_sda_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    host_sda_low = 1'b1;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic bus_stop();
    host_sda_low = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    host_sda_low = 1'b0;
    wait_q();
    wait_q();
  endtask

  task automatic put_bit(input bit b, input bit glitch);
    host_sda_low = !b;
    if (glitch) begin
      repeat (2) @(posedge clk);
      #1 scl = 1'b1;
      @(posedge clk);
      #1 scl = 1'b0;
      repeat (Q - 3) @(posedge clk);
      #1;
    end else begin
      wait_q();
    end
    scl = 1'b1;
    wait_q();
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic get_bit(output bit b);
    host_sda_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    b = (sda_line !== 1'b0);
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output bit ack, input int glitch_bit);
    bit b;
    for (int i = 7; i >= 0; i--) put_bit(d[i], i == glitch_bit);
    get_bit(b);
    ack = !b;
  endtask

  task automatic read_byte(output logic [7:0] d, input bit ack, input logic [7:0] scramble,
                           input logic [7:0] next_val);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) io_in = scramble;
      get_bit(b);
      d[i] = b;
    end
    io_in = next_val;
    put_bit(!ack, 1'b0);
  endtask

  // Reference model state
  logic [7:0] exp_io = 8'h00;
  logic [7:0] wr_data[4];
  logic [7:0] rd_vals[5];
  logic [7:0] rd_scr[4];

  task automatic write_txn(input string tag, input logic [6:0] adr, input int n,
                           input int glitch_bit);
    bit ack;
    bit match;
    int rx0, low0;
    match = (adr == Adr);
    rx0 = rx_pulses;
    low0 = dut_low_cnt;
    bus_start();
    write_byte({adr, 1'b0}, ack, -1);
    check_eq({tag, "_adr_ack"}, 32'(ack), 32'(match));
    for (int i = 0; i < n; i++) begin
      write_byte(wr_data[i], ack, (i == 0) ? glitch_bit : -1);
      check_eq({tag, "_data_ack"}, 32'(ack), 32'(match));
      if (match) exp_io = wr_data[i];
    end
    bus_stop();
    check_eq({tag, "_ioout"}, 32'(io_out), 32'(exp_io));
    check_eq({tag, "_rx_pulses"}, 32'(rx_pulses - rx0), match ? 32'(n) : 32'd0);
    if (!match) check_eq({tag, "_no_drive"}, 32'(dut_low_cnt - low0), 32'd0);
  endtask

  task automatic read_txn(input string tag, input logic [6:0] adr, input int n, input bit extra,
                          input bit rep_start);
    bit ack;
    bit match;
    int tx0, rx0;
    logic [7:0] got;
    logic [7:0] io0;
    match = (adr == Adr);
    tx0 = tx_pulses;
    rx0 = rx_pulses;
    io0 = exp_io;
    bus_start();
    if (rep_start) begin
      write_byte({adr, 1'b0}, ack, -1);
      check_eq({tag, "_wadr_ack"}, 32'(ack), 32'(match));
      bus_start();
    end
    io_in = rd_vals[0];
    write_byte({adr, 1'b1}, ack, -1);
    check_eq({tag, "_adr_ack"}, 32'(ack), 32'(match));
    for (int i = 0; i < n; i++) begin
      read_byte(got, i != n - 1, rd_scr[i], rd_vals[i+1]);
      check_eq({tag, "_rdata"}, 32'(got), match ? 32'(rd_vals[i]) : 32'hFF);
    end
    if (extra) begin
      read_byte(got, 1'b0, 8'h55, 8'h00);
      check_eq({tag, "_after_nack"}, 32'(got), 32'hFF);
    end
    bus_stop();
    check_eq({tag, "_tx_pulses"}, 32'(tx_pulses - tx0), match ? 32'(n) : 32'd0);
    check_eq({tag, "_ioout_kept"}, 32'(io_out), 32'(io0));
    check_eq({tag, "_no_rx"}, 32'(rx_pulses - rx0), 32'd0);
  endtask

  initial begin
    bit ack;
    logic [6:0] adr;
    int n;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ioout", 32'(io_out), 32'h00);
    check_eq("rst_rx_strobe", 32'(rx_ack), 32'd0);
    check_eq("rst_tx_strobe", 32'(tx_ack), 32'd0);
    check_eq("rst_sda", 32'(sda_line), 32'd1);
    reset_n = 1'b1;
    wait_q();

    wr_data[0] = 8'hA5;
    write_txn("wr_match", Adr, 1, -1);

    wr_data[0] = 8'h5A;
    write_txn("wr_miss", 7'h26, 1, -1);

    rd_vals[0] = 8'h3C; rd_vals[1] = 8'h00; rd_scr[0] = 8'hFF;
    read_txn("rd_nack", Adr, 1, 1'b1, 1'b0);

    rd_vals[0] = 8'h3C; rd_vals[1] = 8'hC3; rd_vals[2] = 8'h00;
    rd_scr[0] = 8'hC3; rd_scr[1] = 8'h3C;
    read_txn("rd_two", Adr, 2, 1'b0, 1'b0);

    rd_vals[0] = 8'h96; rd_vals[1] = 8'h00; rd_scr[0] = 8'h69;
    read_txn("rd_rep", Adr, 1, 1'b0, 1'b1);

    // Reset during the 4th data bit of a write
    bus_start();
    write_byte({Adr, 1'b0}, ack, -1);
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    host_sda_low = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    reset_n = 1'b0;
    host_sda_low = 1'b0;
    #1;
    check_eq("rst_mid_sda", 32'(sda_line), 32'd1);
    check_eq("rst_mid_ioout", 32'(io_out), 32'h00);
    exp_io = 8'h00;
    wait_q();
    reset_n = 1'b1;
    wait_q();
    wr_data[0] = 8'h81; wr_data[1] = 8'h7E;
    write_txn("wr_after_rst", Adr, 2, -1);

    // Reset while the slave holds the address ACK: release must not wait for a clock
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(((Adr << 1) >> i) & 1'b1, 1'b0);
    host_sda_low = 1'b0;
    wait_q();
    check_eq("ack_held", 32'(sda_line), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_eq("ack_async_release", 32'(sda_line), 32'd1);
    exp_io = 8'h00;
    wait_q();
    reset_n = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();

    for (int it = 0; it < 8; it++) begin
      adr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : Adr;
      n = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) wr_data[i] = 8'($urandom);
        write_txn("rnd_wr", adr, n, -1);
      end else begin
        for (int i = 0; i < 5; i++) rd_vals[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) rd_scr[i] = 8'($urandom);
        read_txn("rnd_rd", adr, n, 1'b0, 1'b0);
      end
    end

`ifdef I2C_GLITCH_FILTER_EN
    wr_data[0] = 8'hC6;
    write_txn("glitch_wr", Adr, 1, 4);
`endif

    check_eq("strobe_widths", 32'(bad_widths), 32'd0);
    check_eq("ioout_timing", 32'(io_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_reg_slave.md
# i2c_reg_slave

Single-register I2C slave engine: one 7-bit bus address exposing one write register (host→SoC) and one read register (SoC→host). It is the host-facing stage beneath the bytewide serial port. The port instantiates one copy per I2C address and consumes `IOout` and the two completion strobes. The block oversamples SCL/SDA in the system clock domain. It sends a completion strobe when a byte has left (read) and when a byte has arrived (write), so the port can track flow control.

## Interface
- `I2C_ADR`, default 7'h27: 7-bit slave address matched after START.
- `ACK_STRETCH`, default 4: width in `clk` cycles of each completion strobe, from 1 to 15.
- `clk`  in  1  system clock; all logic runs on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `SCL`  in  1  I2C clock from the host; this block never stretches it.
- `SDA`  inout  1  open-drain; driven 0 or left high-Z, never driven 1.
- `IOin`  in  8  read-register value, captured at each read-byte load.
- `IOout`  out  8  last byte written by the host.
- `serialTxDataAck`  out  1  high for `ACK_STRETCH` cycles when a read byte's 9th clock is sampled.
- `serialRxDataAck`  out  1  high for `ACK_STRETCH` cycles when a write byte has been acknowledged.

## Operation
- Input stage: 2-flop synchronizer on SCL and SDA, then registered edge detect. Outputs are `scl_rise`, `scl_fall`, `start` (SDA falls while SCL high) and `stop` (SDA rises while SCL high).
- FSM states: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
- `start` in any state → ADDR, with the bit counter cleared and SDA released. This covers repeated START.
- `stop` in any state → IDLE, with SDA released.
- ADDR: shift SDA in MSB-first on each `scl_rise`. After 8 bits:
  - Address match → ADDR_ACK; drive SDA low at the next `scl_fall`.
  - Mismatch → WAIT_STOP; SDA is never driven.
- ADDR_ACK: release SDA at the `scl_fall` after the 9th clock.
  - R/W=0 → RX_DATA.
  - R/W=1 → TX_DATA; at that same `scl_fall`, load the shifter from `IOin` and drive its MSB.
- RX_DATA: shift in 8 bits on `scl_rise`. At the 8th-bit `scl_fall`, do all of the following, then go to RX_ACK:
  - drive the ACK (SDA low);
  - copy the shifter to `IOout`;
  - start the `serialRxDataAck` stretch counter.
- RX_ACK: release SDA at the next `scl_fall`, then → RX_DATA. Each byte of a multi-byte write overwrites `IOout` and strobes again.
- TX_DATA: on each `scl_fall`, present the next bit. A 0 bit drives SDA low; a 1 bit releases SDA. After the 8th bit's `scl_fall`, release SDA → TX_ACK.
- TX_ACK: on `scl_rise`, sample the host's acknowledge and start the `serialTxDataAck` stretch (on ACK or NACK).
  - ACK (SDA=0) → TX_DATA; reload from `IOin` at the next `scl_fall`.
  - NACK → WAIT_STOP.
- WAIT_STOP: ignore all bits until `start` or `stop`.
- Strobe counters: a new trigger during an active stretch restarts the count. This is only reachable when ACK_STRETCH exceeds a bit time.
- Reset values: `IOout`=8'h00, both strobes 0, SDA high-Z, FSM=IDLE, shifter 0. Reset mid-transfer releases SDA immediately (asynchronously). The engine then ignores the bus until the next START.

## Timing
- `clk` ≥ 10× SCL frequency. SCL high and low phases ≥ 4 `clk` each.
- Edge detection latency: 3 `clk` from the pin (2 sync + 1 edge register); 5 with the filter enabled.
- SDA drive/release changes 1 `clk` after the detected `scl_fall`, well inside the SCL-low phase.
- `IOout` updates in the same cycle that `serialRxDataAck` rises.
- `IOin` is sampled in exactly one cycle per byte, the load cycle; later changes do not alter a byte in flight.
- Strobe width is exactly `ACK_STRETCH` cycles.

## Configuration
- `I2C_GLITCH_FILTER_EN` defined: a 3-tap majority filter follows each synchronizer. This suppresses single-`clk` glitches on SCL/SDA and adds 2 cycles of latency.
- Undefined: synchronizer only, and a 1-cycle glitch can register as an edge.

## Structure
- Shared package `i2c_pkg`: FSM state encoding and the bit-count width constant (4 bits, values 0–8).
- Sub-module `i2c_line_sync`: instantiated once per line (SCL and SDA). Contains the synchronizer, the optional filter and the rise/fall outputs. START/STOP decoding stays in the parent.

## Test plan
- Write [0x4E, 0xA5] with `I2C_ADR`=0x27 → slave ACKs both bytes; `IOout`=0xA5; `serialRxDataAck` high for exactly 4 cycles.
- Write address 0x26 (0x4C, 0x5A) → SDA never driven low; `IOout` unchanged; no strobes.
- `IOin`=0x3C, read [0x4F] with host NACK → host receives 0x3C; `serialTxDataAck` pulses once; FSM in WAIT_STOP until STOP.
- Two-byte read: `IOin` changes from 0x3C to 0xC3 during byte 1; host ACKs then NACKs → bytes 0x3C, 0xC3; two Tx strobes.
- Repeated START after the write address, then read → no `IOout` update; the read returns `IOin` correctly.
- `reset_n` pulsed low during the RX_DATA 4th bit → SDA high-Z at once; `IOout`=0; the next full transfer succeeds. With `I2C_GLITCH_FILTER_EN` defined, a 1-cycle SCL glitch mid-bit does not shift the data.
